// File: rtl/draw_pkg.sv
// Shared constants for the drawing path: screen geometry, arbiter state
// encoding and the fixed requester slot assignment.
package draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int H_RES = 160;
  localparam int V_RES = 120;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int REQ_BOUNDS   = 0;
  localparam int REQ_BALL     = 1;
  localparam int REQ_PADDLE_L = 2;
  localparam int REQ_PADDLE_R = 3;

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Requester pixel-stream bus plus the shared VGA adapter write port.
// master = requester/adapter side, slave = the arbiter.
interface vga_draw_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int X_W   = draw_pkg::X_W,
  parameter int Y_W   = draw_pkg::Y_W,
  parameter int C_W   = draw_pkg::C_W
);

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     pix_valid;
  logic [N_REQ-1:0]     pix_last;
  logic [N_REQ*X_W-1:0] x_in;
  logic [N_REQ*Y_W-1:0] y_in;
  logic [N_REQ*C_W-1:0] colour_in;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     pix_ready;
  logic                 vga_plot;
  logic [X_W-1:0]       vga_x;
  logic [Y_W-1:0]       vga_y;
  logic [C_W-1:0]       vga_colour;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req, pix_valid, pix_last, x_in, y_in, colour_in,
    input  grant, pix_ready, vga_plot, vga_x, vga_y, vga_colour, busy, timeout_err
  );

  modport slave (
    input  req, pix_valid, pix_last, x_in, y_in, colour_in,
    output grant, pix_ready, vga_plot, vga_x, vga_y, vga_colour, busy, timeout_err
  );

endinterface

// File: rtl/vga_draw_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: one-hot first set request at or after
// rr_ptr, wrapping; all zero when nothing is requested.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner
);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] sel;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign hi_mask[gi] = (gi >= int'(rr_ptr));
  end

  // Prefer requests at/after the pointer; otherwise wrap to the lowest one.
  assign req_hi = req & hi_mask;
  assign sel    = (|req_hi) ? req_hi : req;
  assign winner = sel & (~sel + N_REQ'(1));

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin, shape-locked arbiter for the single VGA adapter write port,
// with pixel clipping and an idle-owner watchdog.
module vga_draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int X_W     = draw_pkg::X_W,
  parameter int Y_W     = draw_pkg::Y_W,
  parameter int C_W     = draw_pkg::C_W,
  parameter int H_RES   = draw_pkg::H_RES,
  parameter int V_RES   = draw_pkg::V_RES,
  parameter int TIMEOUT = 20000
) (
  input logic               clock,
  input logic               reset_n,
  vga_draw_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t           state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [PTR_W-1:0] owner_reg;
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [WD_W-1:0]  watchdog_reg;
  logic             plot_reg;
  logic [X_W-1:0]   x_reg;
  logic [Y_W-1:0]   y_reg;
  logic [C_W-1:0]   colour_reg;
  logic             timeout_reg;

  logic [N_REQ-1:0] winner;
  logic [PTR_W-1:0] winner_idx;
  logic [PTR_W-1:0] rr_ptr_next;
  logic             own_req;
  logic             own_valid;
  logic             own_last;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [C_W-1:0]   own_colour;
  logic             in_view;
  logic             wd_expired;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .winner (winner)
  );

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) winner_idx = PTR_W'(i);
    end
  end

  assign own_req     = bus.req[owner_reg];
  assign own_valid   = bus.pix_valid[owner_reg];
  assign own_last    = bus.pix_last[owner_reg];
  assign own_x       = bus.x_in[int'(owner_reg)*X_W +: X_W];
  assign own_y       = bus.y_in[int'(owner_reg)*Y_W +: Y_W];
  assign own_colour  = bus.colour_in[int'(owner_reg)*C_W +: C_W];
  assign in_view     = (int'(own_x) < H_RES) && (int'(own_y) < V_RES);
  assign wd_expired  = (int'(watchdog_reg) == TIMEOUT - 1);
  assign rr_ptr_next = (int'(owner_reg) == N_REQ - 1) ? '0 : owner_reg + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      watchdog_reg <= '0;
      plot_reg     <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      colour_reg   <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      plot_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          watchdog_reg <= '0;
          if (|bus.req) begin
            state_reg <= ST_OWN;
            grant_reg <= winner;
            owner_reg <= winner_idx;
          end
        end
        ST_OWN: begin
          // Abort outranks everything, including a last pixel in the same cycle.
          if (!own_req) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= rr_ptr_next;
          end else if (own_valid) begin
            watchdog_reg <= '0;
            if (in_view) begin
              plot_reg   <= 1'b1;
              x_reg      <= own_x;
              y_reg      <= own_y;
              colour_reg <= own_colour;
            end
            if (own_last) begin
              state_reg  <= ST_IDLE;
              grant_reg  <= '0;
              rr_ptr_reg <= rr_ptr_next;
            end
          end else if (wd_expired) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            rr_ptr_reg  <= rr_ptr_next;
            timeout_reg <= 1'b1;
          end else begin
            watchdog_reg <= watchdog_reg + WD_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.pix_ready   = grant_reg;
  assign bus.vga_plot    = plot_reg;
  assign bus.vga_x       = x_reg;
  assign bus.vga_y       = y_reg;
  assign bus.vga_colour  = colour_reg;
  assign bus.busy        = (state_reg == ST_OWN);
  assign bus.timeout_err = timeout_reg;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: single shape, round-robin rotation,
// clipping, watchdog release, abort and mid-shape reset.
module tb_vga_draw_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  vga_draw_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) bus ();

  vga_draw_arbiter #(
    .N_REQ   (N),
    .X_W     (XW),
    .Y_W     (YW),
    .C_W     (CW),
    .H_RES   (160),
    .V_RES   (120),
    .TIMEOUT (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pix(input int i, input logic v, input logic l,
                           input int x, input int y, input int c);
    bus.pix_valid[i]          = v;
    bus.pix_last[i]           = l;
    bus.x_in[i*XW +: XW]      = XW'(x);
    bus.y_in[i*YW +: YW]      = YW'(y);
    bus.colour_in[i*CW +: CW] = CW'(c);
  endtask

  task automatic clear_pix();
    bus.pix_valid = '0;
    bus.pix_last  = '0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.colour_in = '0;
  endtask

  task automatic chk_plot(input string tag, input int x, input int y, input int c);
    chk({tag, ".plot"}, 32'(bus.vga_plot), 32'd1);
    chk({tag, ".x"}, 32'(bus.vga_x), 32'(x));
    chk({tag, ".y"}, 32'(bus.vga_y), 32'(y));
    chk({tag, ".colour"}, 32'(bus.vga_colour), 32'(c));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.req = '0;
    clear_pix();
    tick();
    tick();

    // Reset state
    chk("rst.grant", 32'(bus.grant), 32'd0);
    chk("rst.plot", 32'(bus.vga_plot), 32'd0);
    chk("rst.x", 32'(bus.vga_x), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.timeout", 32'(bus.timeout_err), 32'd0);

    // Single shape from requester 0
    reset_n = 1'b1;
    tick();
    chk("s1.idle_grant", 32'(bus.grant), 32'd0);
    bus.req = 4'b0001;
    tick();
    chk("s1.grant", 32'(bus.grant), 32'b0001);
    chk("s1.ready", 32'(bus.pix_ready), 32'b0001);
    chk("s1.busy", 32'(bus.busy), 32'd1);
    chk("s1.noplot", 32'(bus.vga_plot), 32'd0);
    drive_pix(0, 1'b1, 1'b0, 10, 5, 3);
    tick();
    chk_plot("s1.p0", 10, 5, 3);
    drive_pix(0, 1'b1, 1'b0, 11, 5, 3);
    tick();
    chk_plot("s1.p1", 11, 5, 3);
    drive_pix(0, 1'b1, 1'b1, 12, 5, 3);
    tick();
    chk_plot("s1.p2", 12, 5, 3);
    chk("s1.released", 32'(bus.grant), 32'd0);
    bus.req = '0;
    clear_pix();
    tick();
    chk("s1.plot_off", 32'(bus.vga_plot), 32'd0);
    chk("s1.idle", 32'(bus.busy), 32'd0);

    // Round-robin rotation from a fresh pointer
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      int o;
      o = s % N;
      tick();
      chk($sformatf("rr%0d.grant", s), 32'(bus.grant), 32'(1 << o));
      for (int i = 0; i < N; i++) drive_pix(i, 1'b1, 1'b0, 30 + i*4, 40 + i, i + 1);
      tick();
      chk_plot($sformatf("rr%0d.p0", s), 30 + o*4, 40 + o, o + 1);
      for (int i = 0; i < N; i++) drive_pix(i, 1'b1, 1'b1, 31 + i*4, 40 + i, i + 1);
      tick();
      chk_plot($sformatf("rr%0d.p1", s), 31 + o*4, 40 + o, o + 1);
      chk($sformatf("rr%0d.gap", s), 32'(bus.grant), 32'd0);
      clear_pix();
    end
    bus.req = '0;
    tick();

    // Clipping: pointer now at 1
    bus.req = 4'b0010;
    tick();
    chk("clip.grant", 32'(bus.grant), 32'b0010);
    drive_pix(1, 1'b1, 1'b0, 200, 10, 5);
    tick();
    chk("clip.dropped", 32'(bus.vga_plot), 32'd0);
    chk("clip.held", 32'(bus.grant), 32'b0010);
    drive_pix(1, 1'b1, 1'b1, 159, 119, 6);
    tick();
    chk_plot("clip.edge", 159, 119, 6);
    chk("clip.released", 32'(bus.grant), 32'd0);
    clear_pix();

    // Watchdog: requester 2 never sends, requester 3 waits behind it
    bus.req = 4'b1100;
    tick();
    chk("wd.grant", 32'(bus.grant), 32'b0100);
    for (int c = 0; c < 15; c++) tick();
    chk("wd.still_owned", 32'(bus.grant), 32'b0100);
    chk("wd.no_err_yet", 32'(bus.timeout_err), 32'd0);
    tick();
    chk("wd.released", 32'(bus.grant), 32'd0);
    chk("wd.err_pulse", 32'(bus.timeout_err), 32'd1);
    chk("wd.no_plot", 32'(bus.vga_plot), 32'd0);
    tick();
    chk("wd.err_cleared", 32'(bus.timeout_err), 32'd0);
    chk("wd.next_grant", 32'(bus.grant), 32'b1000);

    // Abort: owner 3 drops req while presenting a pixel
    drive_pix(3, 1'b1, 1'b0, 50, 50, 2);
    tick();
    chk_plot("abort.p0", 50, 50, 2);
    bus.req = 4'b0101;
    drive_pix(3, 1'b1, 1'b0, 60, 60, 4);
    tick();
    chk("abort.no_plot", 32'(bus.vga_plot), 32'd0);
    chk("abort.released", 32'(bus.grant), 32'd0);
    clear_pix();
    tick();
    chk("abort.ptr_wrap", 32'(bus.grant), 32'b0001);

    // Reset while owning with a pixel presented
    drive_pix(0, 1'b1, 1'b0, 70, 70, 1);
    reset_n = 1'b0;
    tick();
    chk("mrst.grant", 32'(bus.grant), 32'd0);
    chk("mrst.plot", 32'(bus.vga_plot), 32'd0);
    chk("mrst.busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    clear_pix();
    bus.req = 4'b1111;
    tick();
    chk("mrst.regrant", 32'(bus.grant), 32'b0001);
    chk("mrst.plot_idle", 32'(bus.vga_plot), 32'd0);
    bus.req = '0;
    tick();
    tick();
    chk("end.idle", 32'(bus.grant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter write port (plot/x/y/colour) among N_REQ pixel-stream requesters: bounds drawer, ball eraser/drawer, two paddle drawers.
- Grants are round-robin. A grant is locked for a whole shape, from the first pixel to the pixel flagged last.
- Sits between the game control FSM's drawing datapaths and vga_adapter.
- Provides a watchdog so a hung requester cannot starve the screen.

Parameters:
- N_REQ, 4, number of requesters; index 0 is the bounds drawer.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- H_RES, 160, visible width; pixels with x >= H_RES are dropped.
- V_RES, 120, visible height; pixels with y >= V_RES are dropped.
- TIMEOUT, 20000, number of idle owner cycles before a forced release.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester draw request; held high for the whole shape.
- pix_valid  in  N_REQ  requester presents a pixel this cycle.
- pix_last  in  N_REQ  the presented pixel is the last of the shape.
- x_in  in  N_REQ*X_W  packed x coordinates; requester i at bits [i*X_W +: X_W].
- y_in  in  N_REQ*Y_W  packed y coordinates, packed the same way.
- colour_in  in  N_REQ*C_W  packed colours, packed the same way.
- grant  out  N_REQ  registered one-hot current owner; all zero when idle.
- pix_ready  out  N_REQ  equals grant; a pixel is consumed when pix_valid & pix_ready.
- vga_plot  out  1  registered write strobe to vga_adapter.
- vga_x  out  X_W  registered x of the plotted pixel.
- vga_y  out  Y_W  registered y of the plotted pixel.
- vga_colour  out  C_W  registered colour of the plotted pixel.
- busy  out  1  high while a grant is held.
- timeout_err  out  1  one-cycle pulse on a watchdog release.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE; grant, vga_plot and timeout_err = 0.
  - vga_x, vga_y, vga_colour = 0; rr pointer = 0; watchdog = 0.
  - Reset mid-shape drops the grant immediately. No further plot is issued.
- States: IDLE and OWN.
- IDLE:
  - If req is nonzero, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - The grant is registered, so the owner sees grant one cycle after the req it won with.
  - If req is zero, stay in IDLE.
- OWN:
  - pix_ready[owner] = 1; all other pix_ready bits are 0.
  - A pixel is consumed when pix_valid[owner] is high.
  - On the next edge, vga_plot = 1 and vga_x/vga_y/vga_colour take that pixel. Latency is 1 cycle, throughput 1 pixel per cycle.
  - Pixels with x >= H_RES or y >= V_RES are consumed with vga_plot = 0 (clip).
  - pix_valid on non-owners is ignored. Those pixels are not consumed.
- Release to IDLE, with rr_ptr set to (owner+1) mod N_REQ, on the first of:
  - (a) a consumed pixel with pix_last set;
  - (b) req[owner] deasserted (abort; a pixel presented in the same cycle is NOT plotted);
  - (c) watchdog reaching TIMEOUT.
- Gap after release: every release spends at least 1 cycle in IDLE, where grant = 0. Back-to-back shapes from different requesters therefore have a 1-cycle gap.
- Watchdog:
  - Counts OWN cycles without a consumed pixel; clears on every consumed pixel.
  - At TIMEOUT it forces release and pulses timeout_err for 1 cycle.
- Simultaneous events:
  - Consumed last pixel and watchdog expiry in the same cycle: the pixel is plotted, no timeout_err.
  - Last pixel with req dropping in the same cycle: treated as abort, no plot.
- Single requester: it is re-granted after the 1-cycle IDLE gap. No starvation is possible because the pointer always advances past the last owner.
- vga_plot is high for exactly one cycle per accepted pixel and is never high in IDLE, except for the final pixel's plot on the cycle after release.

Decomposition:
- Shared package (draw_pkg):
  - X_W, Y_W, C_W, H_RES, V_RES constants;
  - state encoding constants (IDLE, OWN);
  - requester index constants: REQ_BOUNDS=0, REQ_BALL=1, REQ_PADDLE_L=2, REQ_PADDLE_R=3.
- Sub-module rr_priority_picker: combinational.
  - Inputs: req, rr_ptr.
  - Output: one-hot winner, all zero when req is zero.
  - Reused by any future arbiter in the design.

Test Plan:
- Reset, then req=0001; requester 0 sends 3 pixels (10,5,c3),(11,5,c3),(12,5,c3 last) -> grant=0001 one cycle after req; vga_plot high 3 consecutive cycles with matching x/y/colour; grant=0 on the cycle after last.
- req=1111 held; each shape is 2 pixels -> grant order 0001,0010,0100,1000,0001; a 1-cycle grant=0 gap between shapes.
- Owner 1 sends (200,10) then (159,119 last) -> first pixel clipped (no plot); second plotted at x=159, y=119.
- Owner 2 granted, never asserts pix_valid, TIMEOUT=16 -> release after 16 owner cycles; timeout_err one-cycle pulse; next requester granted after the gap.
- Owner 3 mid-shape drops req while pix_valid=1 -> no plot that cycle; grant=0 next cycle; rr_ptr=0 (requester 0 wins the next arbitration if requesting).
- reset_n low during OWN with pix_valid=1 -> on the next edge grant=0, vga_plot=0, rr_ptr=0; arbitration restarts cleanly.
